// File: rtl/segre_ex_mdu_stage_if.sv
// Opcode package and the ID/TL-facing handshake bundle of the execute stage.
package segre_pkg;
  typedef enum logic [4:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA,
    ALU_OR, ALU_AND, ALU_LUI, ALU_JAL, ALU_JALR,
    ALU_BEQ, ALU_BNE, ALU_BLT, ALU_BGE, ALU_BLTU, ALU_BGEU
  } alu_opcode_e;
endpackage

interface segre_ex_mdu_stage_if #(
  parameter int unsigned WORD_W = 32,
  parameter int unsigned REG_AW = 5
);
  import segre_pkg::*;

  logic              flush_i;
  logic              in_valid_i;
  logic              in_ready_o;
  alu_opcode_e       alu_opcode_i;
  logic              md_en_i;
  logic [2:0]        md_op_i;
  logic [WORD_W-1:0] src_a_i;
  logic [WORD_W-1:0] src_b_i;
  logic [WORD_W-1:0] br_src_a_i;
  logic [WORD_W-1:0] br_src_b_i;
  logic              rf_we_i;
  logic [REG_AW-1:0] rf_waddr_i;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [WORD_W-1:0] res_o;
  logic              rf_we_o;
  logic [REG_AW-1:0] rf_waddr_o;
  logic              tkbr_o;
  logic [WORD_W-1:0] new_pc_o;
  logic              illegal_o;

  modport slave (
    input  flush_i, in_valid_i, alu_opcode_i, md_en_i, md_op_i, src_a_i, src_b_i,
           br_src_a_i, br_src_b_i, rf_we_i, rf_waddr_i, out_ready_i,
    output in_ready_o, out_valid_o, res_o, rf_we_o, rf_waddr_o, tkbr_o, new_pc_o, illegal_o
  );

  modport master (
    output flush_i, in_valid_i, alu_opcode_i, md_en_i, md_op_i, src_a_i, src_b_i,
           br_src_a_i, br_src_b_i, rf_we_i, rf_waddr_i, out_ready_i,
    input  in_ready_o, out_valid_o, res_o, rf_we_o, rf_waddr_o, tkbr_o, new_pc_o, illegal_o
  );
endinterface

// File: rtl/segre_ex_mdu_stage.sv
// Execute stage: single-cycle ALU/branch plus iterative RV M-extension mul/div.
// Divider is built only when SEGRE_EX_DIV_EN is defined; otherwise DIV-class ops flag illegal.
module segre_ex_mdu_stage
  import segre_pkg::*;
#(
  parameter int unsigned WORD_W     = 32,
  parameter int unsigned REG_AW     = 5,
  parameter int unsigned MUL_UNROLL = 1
) (
  input logic              clk_i,
  input logic              rst_i,
  segre_ex_mdu_stage_if.slave bus
);

  localparam int unsigned MUL_K = WORD_W / MUL_UNROLL;
  localparam int unsigned CNT_W = $clog2(WORD_W + 1);
  localparam int unsigned SH_W  = $clog2(WORD_W);

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_e;

  state_e              state, state_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic                done;

  logic                out_valid;
  logic [WORD_W-1:0]   res;
  logic                rf_we;
  logic [REG_AW-1:0]   rf_waddr;
  logic                tkbr;
  logic [WORD_W-1:0]   new_pc;
  logic                illegal;

  logic [2*WORD_W-1:0] prod;
  logic [2*WORD_W-1:0] prod_step;
  logic [WORD_W-1:0]   mcand;
  logic [1:0]          op_q;
  logic                sign_q;
  logic                rf_we_q;
  logic [REG_AW-1:0]   rf_waddr_q;

  logic                in_ready, accept, div_illegal, is_div;
  logic                signed_a, signed_b, a_neg, b_neg;
  logic [WORD_W-1:0]   a_abs, b_abs;
  logic [WORD_W-1:0]   alu_res;
  logic                br_taken;
  logic [WORD_W:0]     mul_sum;
  logic [2*WORD_W-1:0] prod_fix;
  logic [WORD_W-1:0]   mdu_res;

`ifdef SEGRE_EX_DIV_EN
  logic                rem_neg_q;
  logic                b_zero_q;
  logic [WORD_W-1:0]   a_raw_q;
  logic [WORD_W:0]     div_shift, div_diff;
  assign div_illegal = 1'b0;
`else
  assign div_illegal = bus.md_en_i && bus.md_op_i[2];
`endif

  assign in_ready = (state == IDLE) && (!out_valid || bus.out_ready_i);
  assign accept   = bus.in_valid_i && in_ready && !bus.flush_i;
  assign is_div   = bus.md_op_i[2];

  // Operand signedness from funct3: MUL/MULH signed x signed, MULHSU signed x unsigned.
  always_comb begin
    if (is_div) begin
      signed_a = !bus.md_op_i[0];
      signed_b = !bus.md_op_i[0];
    end else begin
      signed_a = (bus.md_op_i[1:0] != 2'b11);
      signed_b = !bus.md_op_i[1];
    end
    a_neg = signed_a && bus.src_a_i[WORD_W-1];
    b_neg = signed_b && bus.src_b_i[WORD_W-1];
    a_abs = a_neg ? (-bus.src_a_i) : bus.src_a_i;
    b_abs = b_neg ? (-bus.src_b_i) : bus.src_b_i;
  end

  always_comb begin
    alu_res = '0;
    unique case (bus.alu_opcode_i)
      ALU_SUB:  alu_res = bus.src_a_i - bus.src_b_i;
      ALU_SLL:  alu_res = bus.src_a_i << bus.src_b_i[SH_W-1:0];
      ALU_SLT:  alu_res = {{(WORD_W-1){1'b0}}, $signed(bus.src_a_i) < $signed(bus.src_b_i)};
      ALU_SLTU: alu_res = {{(WORD_W-1){1'b0}}, bus.src_a_i < bus.src_b_i};
      ALU_XOR:  alu_res = bus.src_a_i ^ bus.src_b_i;
      ALU_SRL:  alu_res = bus.src_a_i >> bus.src_b_i[SH_W-1:0];
      ALU_SRA:  alu_res = WORD_W'($signed(bus.src_a_i) >>> bus.src_b_i[SH_W-1:0]);
      ALU_OR:   alu_res = bus.src_a_i | bus.src_b_i;
      ALU_AND:  alu_res = bus.src_a_i & bus.src_b_i;
      ALU_LUI:  alu_res = bus.src_b_i;
      ALU_JALR: alu_res = (bus.src_a_i + bus.src_b_i) & ~WORD_W'(1);
      default:  alu_res = bus.src_a_i + bus.src_b_i;
    endcase
  end

  always_comb begin
    br_taken = 1'b0;
    unique case (bus.alu_opcode_i)
      ALU_JAL, ALU_JALR: br_taken = 1'b1;
      ALU_BEQ:  br_taken = (bus.br_src_a_i == bus.br_src_b_i);
      ALU_BNE:  br_taken = (bus.br_src_a_i != bus.br_src_b_i);
      ALU_BLT:  br_taken = $signed(bus.br_src_a_i) <  $signed(bus.br_src_b_i);
      ALU_BGE:  br_taken = $signed(bus.br_src_a_i) >= $signed(bus.br_src_b_i);
      ALU_BLTU: br_taken = bus.br_src_a_i <  bus.br_src_b_i;
      ALU_BGEU: br_taken = bus.br_src_a_i >= bus.br_src_b_i;
      default:  br_taken = 1'b0;
    endcase
  end

  // prod holds {acc, multiplier} for MUL and {remainder, dividend/quotient} for DIV.
  always_comb begin
    prod_step = prod;
    mul_sum   = '0;
`ifdef SEGRE_EX_DIV_EN
    div_shift = '0;
    div_diff  = '0;
`endif
    if (state == MUL) begin
      for (int unsigned u = 0; u < MUL_UNROLL; u++) begin
        mul_sum   = {1'b0, prod_step[2*WORD_W-1:WORD_W]} + (prod_step[0] ? {1'b0, mcand} : '0);
        prod_step = {mul_sum, prod_step[WORD_W-1:1]};
      end
    end
`ifdef SEGRE_EX_DIV_EN
    else if (state == DIV) begin
      div_shift = {prod[2*WORD_W-1:WORD_W], prod[WORD_W-1]};
      div_diff  = div_shift - {1'b0, mcand};
      if (!div_diff[WORD_W])
        prod_step = {div_diff[WORD_W-1:0], prod[WORD_W-2:0], 1'b1};
      else
        prod_step = {div_shift[WORD_W-1:0], prod[WORD_W-2:0], 1'b0};
    end
`endif
  end

  always_comb begin
    prod_fix = sign_q ? (-prod_step) : prod_step;
    mdu_res  = (op_q == 2'b00) ? prod_fix[WORD_W-1:0] : prod_fix[2*WORD_W-1:WORD_W];
`ifdef SEGRE_EX_DIV_EN
    if (state == DIV) begin
      if (b_zero_q)
        mdu_res = op_q[1] ? a_raw_q : '1;
      else if (op_q[1])
        mdu_res = rem_neg_q ? (-prod_step[2*WORD_W-1:WORD_W]) : prod_step[2*WORD_W-1:WORD_W];
      else
        mdu_res = sign_q ? (-prod_step[WORD_W-1:0]) : prod_step[WORD_W-1:0];
    end
`endif
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    done      = 1'b0;
    if (bus.flush_i) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept && bus.md_en_i && !div_illegal) begin
            state_nxt = is_div ? DIV : MUL;
            cnt_nxt   = is_div ? CNT_W'(WORD_W) : CNT_W'(MUL_K);
          end
        end
        MUL, DIV: begin
          cnt_nxt = cnt - 1'b1;
          if (cnt == CNT_W'(1)) begin
            done      = 1'b1;
            state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      prod       <= '0;
      mcand      <= '0;
      op_q       <= '0;
      sign_q     <= 1'b0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
`ifdef SEGRE_EX_DIV_EN
      rem_neg_q  <= 1'b0;
      b_zero_q   <= 1'b0;
      a_raw_q    <= '0;
`endif
    end else if (accept && bus.md_en_i && !div_illegal) begin
      prod       <= {{WORD_W{1'b0}}, is_div ? a_abs : b_abs};
      mcand      <= is_div ? b_abs : a_abs;
      op_q       <= bus.md_op_i[1:0];
      sign_q     <= a_neg ^ b_neg;
      rf_we_q    <= bus.rf_we_i;
      rf_waddr_q <= bus.rf_waddr_i;
`ifdef SEGRE_EX_DIV_EN
      rem_neg_q  <= a_neg;
      b_zero_q   <= (bus.src_b_i == '0);
      a_raw_q    <= bus.src_a_i;
`endif
    end else if (state != IDLE) begin
      prod <= prod_step;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_valid <= 1'b0;
      res       <= '0;
      rf_we     <= 1'b0;
      rf_waddr  <= '0;
      tkbr      <= 1'b0;
      new_pc    <= '0;
      illegal   <= 1'b0;
    end else if (bus.flush_i) begin
      out_valid <= 1'b0;
    end else if (accept && (!bus.md_en_i || div_illegal)) begin
      out_valid <= 1'b1;
      rf_waddr  <= bus.rf_waddr_i;
      illegal   <= div_illegal;
      if (div_illegal) begin
        res    <= '0;
        rf_we  <= 1'b0;
        tkbr   <= 1'b0;
        new_pc <= '0;
      end else begin
        res    <= (bus.alu_opcode_i == ALU_JAL || bus.alu_opcode_i == ALU_JALR)
                  ? bus.br_src_a_i : alu_res;
        rf_we  <= bus.rf_we_i;
        tkbr   <= br_taken;
        new_pc <= alu_res;
      end
    end else if (done) begin
      out_valid <= 1'b1;
      res       <= mdu_res;
      rf_we     <= rf_we_q;
      rf_waddr  <= rf_waddr_q;
      tkbr      <= 1'b0;
      new_pc    <= '0;
      illegal   <= 1'b0;
    end else if (bus.out_ready_i) begin
      out_valid <= 1'b0;
    end
  end

  assign bus.in_ready_o  = in_ready;
  assign bus.out_valid_o = out_valid;
  assign bus.res_o       = res;
  assign bus.rf_we_o     = rf_we;
  assign bus.rf_waddr_o  = rf_waddr;
  assign bus.tkbr_o      = tkbr;
  assign bus.new_pc_o    = new_pc;
  assign bus.illegal_o   = illegal;

endmodule
